// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit MIPS-style core.
// The fetch front end uses the opcode values, the word width and the queue entry layout.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_J   = 4'hF;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_LW  = 4'h8;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries between fetch and decode.
// Flush wins over push and pop. A full queue accepts a push when a pop happens in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[head_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= next_ptr(tail_ptr);
            if (do_pop)  head_ptr <= next_ptr(head_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the top masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, predecodes jumps and feeds decode through a small queue.
// Handshake: decode takes the head entry on a rising edge where if_valid and if_ready are both high.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter int          IMEM_DEPTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        redir_valid,
    input  logic [15:0] redir_target,
    output logic        halted,
    output logic        fault,
    output logic [15:0] fetch_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [15:0]      pc;
    logic [15:0]      pc_n;
    logic             fault_n;
    logic             pop;
    logic             push;
    logic             in_range;
    logic             is_jump;
    logic [15:0]      jump_target;
    fetch_entry_t     q_head;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;

    assign pop         = if_valid && if_ready;
    assign in_range    = (32'(pc) < IMEM_DEPTH);
    assign is_jump     = (imem_data[15:12] == OP_J);
    assign jump_target = {pc[15:12], imem_data[11:0]};
    assign push        = (state == ST_RUN) && !redir_valid && in_range && (!q_full || pop);
    assign push_entry  = '{instr: imem_data, pc: pc};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop && !redir_valid),
        .flush     (redir_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign head_entry = q_empty ? '0 : q_head;
    assign if_valid   = (q_count != '0);
    assign if_instr   = head_entry.instr;
    assign if_pc      = head_entry.pc;
    assign imem_addr  = pc;
    assign halted     = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            fault <= fault_n;
            if (push && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 1'b1;
        end
    end

    // A redirect overrides everything; otherwise a jump to itself parks the fetcher in HALT.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        fault_n = fault;
        if (redir_valid) begin
            pc_n = redir_target;
            if (state == ST_HALT) state_n = ST_RUN;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (!in_range) begin
                        fault_n = 1'b1;
                        state_n = ST_HALT;
                    end else if (push) begin
                        if (is_jump) begin
                            if (jump_target == pc) state_n = ST_HALT;
                            else                   pc_n    = jump_target;
                        end else begin
                            pc_n = pc + 16'd1;
                        end
                    end
                end
                ST_HALT: ;
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized ready/redirect run.
// Expected entries come from walking the program image in order.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_target = 16'h0000;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [15:0] mem [16];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 16'd16) ? mem[imem_addr[3:0]] : 16'h0000;

    fetch_sequencer #(.DEPTH(2), .IMEM_DEPTH(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expected fetch stream from a start PC: sequential, jumps followed, ends on self-jump or out of range.
    function automatic void fill(input logic [15:0] start_pc);
        logic [15:0] p;
        logic [15:0] w;
        logic [15:0] tgt;
        p = start_pc;
        exp_q.delete();
        for (int n = 0; n < 64; n++) begin
            if (p >= 16'd16) break;
            w = mem[p[3:0]];
            exp_q.push_back({w, p});
            if (w[15:12] == 4'hF) begin
                tgt = {p[15:12], w[11:0]};
                if (tgt == p) break;
                p = tgt;
            end else begin
                p = p + 16'd1;
            end
        end
    endfunction

    task automatic cycle(input logic rdy, input logic rv, input logic [15:0] tgt);
        logic [31:0] e;
        if_ready     = rdy;
        redir_valid  = rv;
        redir_target = tgt;
        if (rv) begin
            fill(tgt);
        end else if (if_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_pop observed=%h expected=none", {if_instr, if_pc});
            end else begin
                e = exp_q.pop_front();
                check("entry", {if_instr, if_pc}, e);
            end
        end
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_if_instr_pc"}, {if_instr, if_pc}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        start       = 1'b0;
        if_ready    = 1'b0;
        redir_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks(tag);
        rst_n = 1'b1;
        fill(16'h0000);
    endtask

    task automatic pulse_start(input logic rdy);
        start = 1'b1;
        cycle(rdy, 1'b0, 16'h0000);
        start = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(halted && !if_valid) && n < budget) begin
            cycle(1'b1, 1'b0, 16'h0000);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=%0d cycles expected=<%0d", tag, n, budget);
        end
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] saved;
        mem = '{16'h8010, 16'h2116, 16'h2667, 16'h8131, 16'h2552, 16'hE3A2, 16'h0A12, 16'h6322,
                16'h2414, 16'hE7F9, 16'h6A21, 16'hF00B, 16'h1234, 16'h5678, 16'h0BCD, 16'h4321};

        // Free-running fetch to the self-jump at 11.
        do_reset("rst1");
        pulse_start(1'b1);
        check("no_bypass", 32'(if_valid), 32'd0);
        drain("t1", 60);
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_pc", 32'(imem_addr), 32'd11);
        check("t1_fetch_count", 32'(fetch_count), 32'd12);
        check("t1_fault", 32'(fault), 32'd0);

        // Decode stalled: the queue fills to DEPTH and holds.
        do_reset("rst2");
        pulse_start(1'b0);
        repeat (4) cycle(1'b0, 1'b0, 16'h0000);
        check("t2_fetch_count", 32'(fetch_count), 32'd2);
        check("t2_pc", 32'(imem_addr), 32'd2);
        check("t2_head", {if_instr, if_pc}, 32'h8010_0000);
        drain("t2", 60);
        check("t2_fetch_count_end", 32'(fetch_count), 32'd12);

        // Redirect in IDLE, then flush of a full queue.
        do_reset("rst3");
        cycle(1'b0, 1'b1, 16'd8);
        check("t3_idle_halted", 32'(halted), 32'd0);
        check("t3_idle_pc", 32'(imem_addr), 32'd8);
        pulse_start(1'b0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000);
        check("t3_full_pc", 32'(imem_addr), 32'd10);
        check("t3_full_head", 32'(if_pc), 32'd8);
        cycle(1'b0, 1'b1, 16'd7);
        check("t3_flushed", 32'(if_valid), 32'd0);
        check("t3_redir_pc", 32'(imem_addr), 32'd7);
        drain("t3", 60);
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_halt_pc", 32'(imem_addr), 32'd11);

        // Redirect out of HALT restarts fetch.
        cycle(1'b1, 1'b1, 16'd0);
        check("t4_resume", 32'(halted), 32'd0);
        drain("t4", 60);
        check("t4_fetch_count", 32'(fetch_count), 32'd19);

        // Forward jump skips pc 4.
        saved  = mem[3];
        mem[3] = 16'hF005;
        do_reset("rst5");
        pulse_start(1'b1);
        drain("t5", 60);
        check("t5_fetch_count", 32'(fetch_count), 32'd11);
        mem[3] = saved;

        // Out-of-range fault, re-fault from HALT, then asynchronous reset.
        do_reset("rst6");
        pulse_start(1'b1);
        repeat (3) cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 16'd16);
        check("t6_no_fault_yet", 32'(fault), 32'd0);
        cycle(1'b0, 1'b0, 16'h0000);
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_halted", 32'(halted), 32'd1);
        check("t6_no_push", 32'(fetch_count), 32'd3);
        check("t6_empty", 32'(if_valid), 32'd0);
        cycle(1'b0, 1'b1, 16'd16);
        check("t6_rerun", 32'(halted), 32'd0);
        cycle(1'b0, 1'b0, 16'h0000);
        check("t6_refault_halted", 32'(halted), 32'd1);
        check("t6_fault_sticky", 32'(fault), 32'd1);
        cycle(1'b1, 1'b1, 16'd0);
        repeat (2) cycle(1'b1, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async");

        // Random ready and redirect traffic; targets stay inside the program.
        do_reset("rst7");
        pulse_start(1'b1);
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  16'($urandom_range(0, 11)));
        end
        drain("rnd", 80);
        check("rnd_halted", 32'(halted), 32'd1);
        check("rnd_fault", 32'(fault), 32'd0);
        check("rnd_pc", 32'(imem_addr), 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
